// File: rtl/mincore_cpu_if.sv
// Instruction and data memory bus between the core and its memories.
interface mincore_cpu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_wenable;
    logic [1:0]        dmem_write_typ;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output dmem_addr,
        input  dmem_rdata,
        output dmem_wdata,
        output dmem_wenable,
        output dmem_write_typ
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  dmem_addr,
        output dmem_rdata,
        input  dmem_wdata,
        input  dmem_wenable,
        input  dmem_write_typ
    );
endinterface

// File: rtl/mincore_cpu.sv
// Single-cycle RV32I core: fetch, decode, execute and commit in one clk.
module mincore_cpu #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    mincore_cpu_if.master  bus
);
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] regs [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [DATA_W-1:0] op_b, alu_res, load_val, rd_val, mem_addr;
    logic [ADDR_W-1:0] pc_plus4, next_pc;
    logic [4:0]  shamt;
    logic        alu_alt, taken, load_ok, rd_we, store_c;

    assign instr  = bus.imem_rdata;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc_plus4 = pc + ADDR_W'(4);

    // Only SRAI among immediate ops takes funct7[5]; OP uses it for SUB and SRA.
    assign op_b    = (opcode == OP_OP) ? rs2_val : imm_i;
    assign shamt   = op_b[4:0];
    assign alu_alt = instr[30] && ((opcode == OP_OP) || (funct3 == 3'b101));

    // Integer ALU shared by OP and OP-IMM.
    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alu_alt ? (rs1_val - op_b) : (rs1_val + op_b);
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = DATA_W'($signed(rs1_val) < $signed(op_b));
            3'b011: alu_res = DATA_W'(rs1_val < op_b);
            3'b100: alu_res = rs1_val ^ op_b;
            3'b101: alu_res = alu_alt ? DATA_W'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
            3'b110: alu_res = rs1_val | op_b;
            3'b111: alu_res = rs1_val & op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition; funct3 2/3 are reserved and never taken.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = (rs1_val == rs2_val);
            3'b001: taken = (rs1_val != rs2_val);
            3'b100: taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: taken = (rs1_val < rs2_val);
            3'b111: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    // Load extraction from the little-endian read word.
    always_comb begin
        load_val = '0;
        load_ok  = 1'b1;
        case (funct3)
            3'b000: load_val = {{24{bus.dmem_rdata[7]}}, bus.dmem_rdata[7:0]};
            3'b001: load_val = {{16{bus.dmem_rdata[15]}}, bus.dmem_rdata[15:0]};
            3'b010: load_val = bus.dmem_rdata;
            3'b100: load_val = {24'b0, bus.dmem_rdata[7:0]};
            3'b101: load_val = {16'b0, bus.dmem_rdata[15:0]};
            default: load_ok = 1'b0;
        endcase
    end

    // Instruction-level control: next PC, writeback and store request.
    always_comb begin
        next_pc  = pc_plus4;
        rd_we    = 1'b0;
        rd_val   = alu_res;
        store_c  = 1'b0;
        mem_addr = rs1_val + imm_i;
        case (opcode)
            OP_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OP_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = DATA_W'(pc) + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = DATA_W'(pc_plus4);
                next_pc = pc + ADDR_W'(imm_j);
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_val  = DATA_W'(pc_plus4);
                next_pc = ADDR_W'((rs1_val + imm_i) & ~DATA_W'(1));
            end
            OP_BRANCH: begin
                if (taken) next_pc = pc + ADDR_W'(imm_b);
            end
            OP_LOAD: begin
                rd_we  = load_ok;
                rd_val = load_val;
            end
            OP_STORE: begin
                mem_addr = rs1_val + imm_s;
                store_c  = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
            end
            OP_IMM, OP_OP: begin
                rd_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.imem_addr      = pc;
    assign bus.dmem_addr      = ADDR_W'(mem_addr);
    assign bus.dmem_wdata     = rs2_val;
    assign bus.dmem_wenable   = store_c & ~rst;
    assign bus.dmem_write_typ = funct3[1:0];

    // Architectural state commit; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= next_pc;
            if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
        end
    end
endmodule

// File: tb/tb_mincore_cpu.sv
// Self-checking bench for mincore_cpu: directed programs plus random ALU programs.
module tb_mincore_cpu;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] SYS = 32'h0000_0073;
    localparam logic [31:0] CONSOLE = 32'h1000_0000;

    localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4;
    localparam int A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [31:0] imem [256];
    logic [7:0]  dmem [1024];
    logic [9:0]  da;
    logic        poke_req = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [31:0] st_addr, st_wdata;
    logic [1:0]  st_typ;
    logic [7:0]  con_char;
    int          st_count = 0;

    always #5 clk = ~clk;

    mincore_cpu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mincore_cpu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.imem_rdata = imem[bus.imem_addr[9:2]];
    assign da = bus.dmem_addr[9:0];
    assign bus.dmem_rdata = {dmem[da + 10'd3], dmem[da + 10'd2], dmem[da + 10'd1], dmem[da]};

    // Data memory / console model: byte-lane placement happens here.
    always @(posedge clk) begin
        if (poke_req) begin
            dmem[poke_addr]         <= poke_data[7:0];
            dmem[poke_addr + 10'd1] <= poke_data[15:8];
            dmem[poke_addr + 10'd2] <= poke_data[23:16];
            dmem[poke_addr + 10'd3] <= poke_data[31:24];
        end else if (bus.dmem_wenable) begin
            st_count <= st_count + 1;
            st_addr  <= bus.dmem_addr;
            st_wdata <= bus.dmem_wdata;
            st_typ   <= bus.dmem_write_typ;
            if (bus.dmem_addr == CONSOLE) begin
                con_char <= bus.dmem_wdata[7:0];
            end else begin
                dmem[da] <= bus.dmem_wdata[7:0];
                if (bus.dmem_write_typ != 2'd0) dmem[da + 10'd1] <= bus.dmem_wdata[15:8];
                if (bus.dmem_write_typ == 2'd2) begin
                    dmem[da + 10'd2] <= bus.dmem_wdata[23:16];
                    dmem[da + 10'd3] <= bus.dmem_wdata[31:24];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [11:0] im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
        return {20'(imm20), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [20:0] im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic logic [31:0] mem_word(int addr);
        logic [9:0] a = 10'(addr);
        return {dmem[a + 10'd3], dmem[a + 10'd2], dmem[a + 10'd1], dmem[a]};
    endfunction

    // Reference arithmetic for the named ALU operations.
    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        case (op)
            A_ADD:  return a + b;
            A_SUB:  return a - b;
            A_SLL:  return a << b[4:0];
            A_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            A_SLTU: return (a < b) ? 32'd1 : 32'd0;
            A_XOR:  return a ^ b;
            A_SRL:  return a >> b[4:0];
            A_SRA:  return 32'($signed(a) >>> b[4:0]);
            A_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic poke_word(input int addr, input logic [31:0] data);
        poke_addr = 10'(addr);
        poke_data = data;
        poke_req  = 1'b1;
        @(posedge clk);
        #1 poke_req = 1'b0;
    endtask

    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = SYS;
    endtask

    task automatic run_to_system(input int budget);
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (bus.imem_rdata !== SYS && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_system", bus.imem_rdata, SYS);
        if (bus.imem_rdata === SYS) $display("exit with system: %08h", bus.imem_rdata);
    endtask

    initial begin
        int f3_of [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int iops [9] = '{A_ADD, A_SLT, A_SLTU, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA};
        logic [31:0] m [32];
        logic [31:0] orv;
        int n;

        // Arithmetic basics and reset values.
        for (int i = 0; i < 256; i++) imem[i] = SYS;
        imem[0] = enc_i(5, 0, 0, 1, 7'h13);
        imem[1] = enc_i(-7, 1, 0, 2, 7'h13);
        imem[2] = enc_r(32, 2, 1, 0, 3);
        #2 rst = 1'b1;
        #1;
        check("rst_pc", bus.imem_addr, 32'h0);
        check("rst_wen", 32'(bus.dmem_wenable), 32'h0);
        check("rst_x1", dut.regs[1], 32'h0);
        run_to_system(50);
        check("arith_x1", dut.regs[1], 32'd5);
        check("arith_x2", dut.regs[2], 32'hFFFF_FFFE);
        check("arith_x3", dut.regs[3], 32'd7);
        check("arith_pc", bus.imem_addr, 32'hC);

        // Console byte store.
        begin_prog();
        imem[0] = enc_u(32'h10000, 4, 7'h37);
        imem[1] = enc_i(32'h41, 0, 0, 5, 7'h13);
        imem[2] = enc_s(0, 5, 4, 0);
        run_to_system(50);
        check("sb_count", 32'(st_count), 32'd1);
        check("sb_addr", st_addr, CONSOLE);
        check("sb_typ", 32'(st_typ), 32'd0);
        check("sb_wdata", {24'b0, st_wdata[7:0]}, 32'h41);
        check("console", 32'(con_char), 32'h41);
        $display("console: %c", con_char);

        // Word store followed by every load width.
        begin_prog();
        imem[0] = enc_u(32'hDEADC, 1, 7'h37);
        imem[1] = enc_i(-273, 1, 0, 1, 7'h13);
        imem[2] = enc_s(0, 1, 0, 2);
        imem[3] = enc_i(0, 0, 0, 2, 7'h03);
        imem[4] = enc_i(0, 0, 4, 3, 7'h03);
        imem[5] = enc_i(0, 0, 1, 4, 7'h03);
        imem[6] = enc_i(0, 0, 5, 5, 7'h03);
        imem[7] = enc_i(0, 0, 2, 6, 7'h03);
        run_to_system(50);
        check("sw_typ", 32'(st_typ), 32'd2);
        check("lb", dut.regs[2], 32'hFFFF_FFEF);
        check("lbu", dut.regs[3], 32'h0000_00EF);
        check("lh", dut.regs[4], 32'hFFFF_BEEF);
        check("lhu", dut.regs[5], 32'h0000_BEEF);
        check("lw", dut.regs[6], 32'hDEAD_BEEF);

        // Branches, jumps and x0.
        begin_prog();
        imem[0]  = enc_i(1, 0, 0, 1, 7'h13);
        imem[1]  = enc_i(1, 0, 0, 2, 7'h13);
        imem[2]  = enc_b(8, 2, 1, 0);
        imem[3]  = enc_i(1, 0, 0, 10, 7'h13);
        imem[4]  = enc_b(8, 2, 1, 1);
        imem[5]  = enc_i(1, 0, 0, 11, 7'h13);
        imem[6]  = enc_i(-1, 0, 0, 3, 7'h13);
        imem[7]  = enc_b(8, 1, 3, 6);
        imem[8]  = enc_j(8, 1);
        imem[9]  = enc_i(1, 0, 0, 13, 7'h13);
        imem[10] = enc_b(8, 2, 3, 4);
        imem[11] = enc_i(1, 0, 0, 14, 7'h13);
        imem[12] = enc_u(0, 7, 7'h17);
        imem[13] = enc_i(32'h11, 7, 0, 9, 7'h67);
        imem[14] = enc_i(1, 0, 0, 15, 7'h13);
        imem[15] = enc_i(2, 0, 0, 15, 7'h13);
        imem[16] = enc_i(1, 0, 0, 0, 7'h13);
        imem[17] = enc_r(0, 0, 0, 0, 16);
        run_to_system(50);
        check("beq_taken", dut.regs[10], 32'h0);
        check("bne_not_taken", dut.regs[11], 32'h1);
        check("bltu_not_taken", dut.regs[13], 32'h0);
        check("jal_link", dut.regs[1], 32'h24);
        check("blt_taken", dut.regs[14], 32'h0);
        check("auipc", dut.regs[7], 32'h30);
        check("jalr_link", dut.regs[9], 32'h38);
        check("jalr_skip", dut.regs[15], 32'h0);
        check("x0_read", dut.regs[16], 32'h0);
        check("branch_pc", bus.imem_addr, 32'h48);

        // Random ALU programs against a named-operation model.
        for (int p = 0; p < 3; p++) begin
            logic [31:0] pcm;
            begin_prog();
            for (int r = 0; r < 32; r++) m[r] = '0;
            pcm = '0;
            for (int k = 0; k < 40; k++) begin
                int sel = int'($urandom_range(0, 20));
                int rd  = int'($urandom_range(0, 7));
                int rs1 = int'($urandom_range(0, 7));
                int rs2 = int'($urandom_range(0, 7));
                logic [11:0] im12 = 12'($urandom);
                logic [19:0] u20  = 20'($urandom);
                logic [4:0]  sh   = 5'($urandom);
                logic [31:0] res;
                if (sel < 10) begin
                    imem[k] = enc_r((sel == A_SUB || sel == A_SRA) ? 32 : 0, rs2, rs1, f3_of[sel], rd);
                    res = ref_alu(sel, m[rs1], m[rs2]);
                end else if (sel < 19) begin
                    int op = iops[sel - 10];
                    if (op == A_SLL || op == A_SRL || op == A_SRA) begin
                        imem[k] = enc_i((op == A_SRA ? 32'h400 : 32'h0) | int'(sh), rs1, f3_of[op], rd, 7'h13);
                        res = ref_alu(op, m[rs1], 32'(sh));
                    end else begin
                        imem[k] = enc_i(int'(im12), rs1, f3_of[op], rd, 7'h13);
                        res = ref_alu(op, m[rs1], {{20{im12[11]}}, im12});
                    end
                end else if (sel == 19) begin
                    imem[k] = enc_u(int'(u20), rd, 7'h37);
                    res = {u20, 12'b0};
                end else begin
                    imem[k] = enc_u(int'(u20), rd, 7'h17);
                    res = pcm + {u20, 12'b0};
                end
                if (rd != 0) m[rd] = res;
                pcm = pcm + 32'd4;
            end
            run_to_system(100);
            for (int r = 1; r < 32; r++) check($sformatf("rand%0d_x%0d", p, r), dut.regs[r], m[r]);
        end

        // Reset held and asserted mid-run: no stores, state cleared at once.
        begin_prog();
        imem[0] = enc_s(32'h104, 0, 0, 2);
        imem[1] = enc_i(32'h55, 0, 0, 1, 7'h13);
        imem[2] = enc_i(32'h100, 0, 0, 2, 7'h13);
        imem[3] = enc_s(0, 1, 2, 2);
        imem[4] = enc_i(1, 1, 0, 1, 7'h13);
        imem[5] = enc_j(-8, 0);
        poke_word(32'h104, 32'hA5A5_A5A5);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("hold_wen", 32'(bus.dmem_wenable), 32'h0);
        check("hold_nostore", mem_word(32'h104), 32'hA5A5_A5A5);
        rst = 1'b0;
        n = 0;
        while (bus.imem_addr !== 32'h10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_loop", bus.imem_addr, 32'h10);
        check("loop_store", mem_word(32'h100), 32'h55);
        #2 rst = 1'b1;
        #1;
        orv = '0;
        for (int r = 1; r < 32; r++) orv = orv | dut.regs[r];
        check("mid_rst_pc", bus.imem_addr, 32'h0);
        check("mid_rst_regs", orv, 32'h0);
        check("mid_rst_wen", 32'(bus.dmem_wenable), 32'h0);
        poke_word(32'h104, 32'h5A5A_5A5A);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_nostore", mem_word(32'h104), 32'h5A5A_5A5A);
        rst = 1'b0;
        #1 check("release_pc", bus.imem_addr, 32'h0);
        @(posedge clk);
        #1 check("first_step_pc", bus.imem_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
